// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the oversampling UART receiver:
//   - uart_state_e : receive FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - SAMPLE_LO/MID/HI : oversample indices voted on inside each bit (16x)
//   - calc_tick_div / calc_tick_cnt_w : baud-tick divider and its counter width
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;

  // Clocks per oversample tick, integer-truncated.
  function automatic int calc_tick_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  // Smallest width that can hold 0..div-1 (at least 1 bit).
  function automatic int calc_tick_cnt_w(input int div);
    int w;
    w = 1;
    while ((1 << w) < div) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Free-running oversample tick generator on the system clock.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-high reset (counter to 0)
//     clr  - synchronous clear, restarts the tick phase (start-edge align)
//     tick - one-clk pulse while the counter sits at TICK_DIV-1
module uart_baud_tick #(
  parameter int TICK_DIV = 651,
  parameter int CNT_W    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   16x oversampling 8N1 UART receiver (LSB first) with majority-vote
//   sampling at indices 7/8/9 of every bit, including start and stop.
//   Ports:
//     clk       - system clock, rising edge
//     rst       - asynchronous active-high reset
//     rxd       - asynchronous serial line, idle high
//     bdata     - last correctly framed byte, held until the next good frame
//     rx_begin  - one-clk pulse when a start bit is validated
//     rx_ack    - one-clk pulse, coincident with the bdata update
//     frame_err - one-clk pulse when the stop bit votes low
//     busy      - high whenever the FSM is not in IDLE
//     state_dbg - current receive FSM state
//
//   Strobe semantics: rx_begin, rx_ack and frame_err are fire-and-forget
//   single-cycle pulses with no back-pressure; at most one is high in any
//   cycle, and the consumer must sample them on the cycle they are high.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [7:0]  bdata,
  output logic        rx_begin,
  output logic        rx_ack,
  output logic        frame_err,
  output logic        busy,
  output uart_state_e state_dbg
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TICK_W   = calc_tick_cnt_w(TICK_DIV);

  // Two-flop synchroniser; resets to the idle level so reset never looks
  // like a start edge.
  logic rxd_meta_q;
  logic rxs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

  logic tick;
  logic tick_clr;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (TICK_W)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  uart_state_e state_q,     state_d;
  logic [3:0]  s_q,         s_d;
  logic [2:0]  bit_q,       bit_d;
  logic [1:0]  samp_q,      samp_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  bdata_q,     bdata_d;
  logic        armed_q,     armed_d;
  logic        rx_begin_q,  rx_begin_d;
  logic        rx_ack_q,    rx_ack_d;
  logic        frame_err_q, frame_err_d;

  logic maj;
  logic decide;

  // The third vote is taken live from rxs on the SAMPLE_HI tick.
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  assign decide = tick && (s_q == SAMPLE_HI);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    bit_d       = bit_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    bdata_d     = bdata_q;
    armed_d     = 1'b0;
    rx_begin_d  = 1'b0;
    rx_ack_d    = 1'b0;
    frame_err_d = 1'b0;
    tick_clr    = 1'b0;

    // Sample index wraps 15 -> 0 naturally in 4 bits.
    if (tick) begin
      s_d = s_q + 4'd1;
    end

    if (state_q != IDLE && tick) begin
      if (s_q == SAMPLE_LO)  samp_d[0] = rxs_q;
      if (s_q == SAMPLE_MID) samp_d[1] = rxs_q;
    end

    case (state_q)
      IDLE: begin
        // armed needs the line seen high first, so a held-low line (break
        // or a failed stop bit) cannot start a new frame.
        armed_d = armed_q | rxs_q;
        if (armed_q && !rxs_q) begin
          tick_clr = 1'b1;
          s_d      = 4'd0;
          armed_d  = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (decide) begin
          if (!maj) begin
            rx_begin_d = 1'b1;
            bit_d      = 3'd0;
            state_d    = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[7:1]};
          // Bit index moves on after each decision; DATA is entered
          // mid-start-bit so a wrap-based advance would skip bit 0.
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (decide) begin
          if (maj) begin
            bdata_d  = shift_q;
            rx_ack_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 4'd0;
      bit_q       <= 3'd0;
      samp_q      <= 2'b00;
      shift_q     <= 8'h00;
      bdata_q     <= 8'h00;
      armed_q     <= 1'b0;
      rx_begin_q  <= 1'b0;
      rx_ack_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      bit_q       <= bit_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      bdata_q     <= bdata_d;
      armed_q     <= armed_d;
      rx_begin_q  <= rx_begin_d;
      rx_ack_q    <= rx_ack_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bdata     = bdata_q;
  assign rx_begin  = rx_begin_q;
  assign rx_ack    = rx_ack_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
//   Directed bench for uart_rx_sampler at CLK_HZ=1_600_000, BAUD=10_000
//   (10 clk per tick, 160 clk per bit). Line stimulus changes on the
//   falling clock edge; outputs are observed on the falling edge.
module tb_uart_rx_sampler;
  import uart_pkg::*;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int BIT_CLK = 160;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [7:0]  bdata;
  logic        rx_begin;
  logic        rx_ack;
  logic        frame_err;
  logic        busy;
  uart_state_e state_dbg;

  always #5 clk = ~clk;

  uart_rx_sampler #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .bdata     (bdata),
    .rx_begin  (rx_begin),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int begin_cnt = 0;
  int ack_cnt   = 0;
  int ferr_cnt  = 0;
  logic prev_begin = 1'b0;
  logic prev_ack   = 1'b0;
  logic prev_ferr  = 1'b0;

  always @(negedge clk) begin
    if (rx_begin)  begin_cnt++;
    if (rx_ack)    ack_cnt++;
    if (frame_err) ferr_cnt++;
    if (rx_begin || rx_ack || frame_err)
      check_eq("strobe_excl", 32'(rx_begin) + 32'(rx_ack) + 32'(frame_err), 32'd1);
    if (rx_begin)  check_eq("begin_width", 32'(prev_begin), 32'd0);
    if (rx_ack)    check_eq("ack_width",   32'(prev_ack),   32'd0);
    if (frame_err) check_eq("ferr_width",  32'(prev_ferr),  32'd0);
    if (rx_ack) begin
      check_eq("ack_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("ack_bdata", 32'(bdata), 32'(exp_q.pop_front()));
      check_eq("ack_busy", 32'(busy), 32'd0);
    end
    prev_begin = rx_begin;
    prev_ack   = rx_ack;
    prev_ferr  = frame_err;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // gbit >= 0 inverts data bit gbit for glen clk starting goff clk into it.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int gbit, input int goff, input int glen);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        drive_bit(d[i], goff);
        drive_bit(~d[i], glen);
        drive_bit(d[i], BIT_CLK - goff - glen);
      end else begin
        drive_bit(d[i], BIT_CLK);
      end
    end
    drive_bit(stop_v, BIT_CLK);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_bdata"},  32'(bdata),     32'h00);
    check_eq({tag, "_begin"},  32'(rx_begin),  32'd0);
    check_eq({tag, "_ack"},    32'(rx_ack),    32'd0);
    check_eq({tag, "_ferr"},   32'(frame_err), 32'd0);
    check_eq({tag, "_busy"},   32'(busy),      32'd0);
    check_eq({tag, "_state"},  32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  int b0, a0, f0;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    drive_bit(1'b1, 20);

    // 1: clean 0x55
    b0 = begin_cnt; a0 = ack_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, -1, 0, 0);
      begin
        repeat (500) @(negedge clk);
        check_eq("t1_busy_mid", 32'(busy), 32'd1);
      end
    join
    drive_bit(1'b1, 20);
    check_eq("t1_begins", 32'(begin_cnt - b0), 32'd1);
    check_eq("t1_acks",   32'(ack_cnt - a0),   32'd1);
    check_eq("t1_ferrs",  32'(ferr_cnt - f0),  32'd0);
    check_eq("t1_bdata",  32'(bdata),          32'h55);
    check_eq("t1_busy",   32'(busy),           32'd0);

    // 2: back-to-back 0xA3, 0x0F
    b0 = begin_cnt; a0 = ack_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, 1'b1, -1, 0, 0);
    send_frame(8'h0F, 1'b1, -1, 0, 0);
    drive_bit(1'b1, 20);
    check_eq("t2_begins", 32'(begin_cnt - b0), 32'd2);
    check_eq("t2_acks",   32'(ack_cnt - a0),   32'd2);
    check_eq("t2_ferrs",  32'(ferr_cnt - f0),  32'd0);
    check_eq("t2_bdata",  32'(bdata),          32'h0F);

    // 3: 30-clk glitch on an idle line is a false start
    b0 = begin_cnt; a0 = ack_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, 30);
    check_eq("t3_busy_glitch", 32'(busy), 32'd1);
    drive_bit(1'b1, 200);
    check_eq("t3_begins", 32'(begin_cnt - b0), 32'd0);
    check_eq("t3_acks",   32'(ack_cnt - a0),   32'd0);
    check_eq("t3_busy",   32'(busy),           32'd0);
    check_eq("t3_bdata",  32'(bdata),          32'h0F);

    // 4: 0x7E with low stop, 5-bit break, then 0x31
    b0 = begin_cnt; a0 = ack_cnt; f0 = ferr_cnt;
    send_frame(8'h7E, 1'b0, -1, 0, 0);
    check_eq("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
    check_eq("t4_acks", 32'(ack_cnt - a0),  32'd0);
    b0 = begin_cnt;
    drive_bit(1'b0, 5 * BIT_CLK);
    check_eq("t4_hold_begins", 32'(begin_cnt - b0), 32'd0);
    check_eq("t4_hold_busy",   32'(busy),           32'd0);
    check_eq("t4_hold_bdata",  32'(bdata),          32'h0F);
    drive_bit(1'b1, BIT_CLK);
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1, -1, 0, 0);
    drive_bit(1'b1, 20);
    check_eq("t4_acks_after", 32'(ack_cnt - a0),  32'd1);
    check_eq("t4_ferr_total", 32'(ferr_cnt - f0), 32'd1);
    check_eq("t4_bdata",      32'(bdata),         32'h31);

    // 5: reset in data bit 4 of 0xC8 (bits LSB first: 0,0,0,1,0,0,1,1)
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b0, 80);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_rst");
    b0 = begin_cnt; a0 = ack_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, 79);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, 80);
    rst = 1'b0;
    drive_bit(1'b1, 80);
    drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b1, BIT_CLK);
    check_eq("t5_abort_begins", 32'(begin_cnt - b0), 32'd0);
    check_eq("t5_abort_acks",   32'(ack_cnt - a0),   32'd0);
    check_eq("t5_abort_ferrs",  32'(ferr_cnt - f0),  32'd0);
    exp_q.push_back(8'hC8);
    send_frame(8'hC8, 1'b1, -1, 0, 0);
    drive_bit(1'b1, 20);
    check_eq("t5_acks",  32'(ack_cnt - a0), 32'd1);
    check_eq("t5_bdata", 32'(bdata),        32'hC8);

    // 6: 0xFF with bit 2 inverted for one tick around its s=8 sample
    b0 = begin_cnt; a0 = ack_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 2, 85, 10);
    drive_bit(1'b1, 20);
    check_eq("t6_acks",  32'(ack_cnt - a0),  32'd1);
    check_eq("t6_ferrs", 32'(ferr_cnt - f0), 32'd0);
    check_eq("t6_bdata", 32'(bdata),         32'hFF);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
